// File: rtl/regfile_pkg.sv
// regfile_pkg: shared offsets, types and region decode enum for the host register bank
package regfile_pkg;
    localparam int ADDR_WIDTH = 14;
    localparam int DATA_WIDTH = 16;
    localparam int OFS_RO = 'h40;
    localparam int OFS_EVT = 'h60;
    localparam int OFS_MASK = 'h61;
    localparam int OFS_DIRTY = 'h62;
    localparam int OFS_CMD = 'h80;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef enum logic [2:0] {RW, RO, EVT, MASK, DIRTY, CMD, NONE} region_e;
endpackage

// File: rtl/regfile_evt_sticky.sv
// regfile_evt_sticky: sticky event bits with W1C clear, mask and registered interrupt
module regfile_evt_sticky #(
    parameter int N_EVT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_EVT-1:0] evt_in,
    input  logic             clr_en,
    input  logic             mask_we,
    input  logic [N_EVT-1:0] wdata,
    output logic [N_EVT-1:0] evt_sticky,
    output logic [N_EVT-1:0] evt_mask,
    output logic             irq
);
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_sticky <= '0;
            evt_mask <= '0;
            irq <= 1'b0;
        end else begin
            // set is OR'd after the clear so a same-cycle event survives the W1C
            evt_sticky <= (evt_sticky & ~(clr_en ? wdata : '0)) | evt_in;
            if (mask_we) evt_mask <= wdata;
            irq <= |(evt_sticky & evt_mask);
        end
    end
endmodule

// File: rtl/regfile_bank_dbuf.sv
// regfile_bank_dbuf: double-buffered host config bank with status, sticky events and command pulses
module regfile_bank_dbuf
    import regfile_pkg::*;
#(
    parameter int                     ADDR_W = 14,
    parameter int                     DATA_W = 16,
    parameter logic [ADDR_W-1:0]      BASE   = '0,
    parameter int                     N_RW   = 11,
    parameter logic [N_RW*DATA_W-1:0] RW_RST = '0,
    parameter int                     N_RO   = 2,
    parameter int                     N_EVT  = 16,
    parameter int                     CMD_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        write_data,
    output logic [DATA_W-1:0]        read_data,
    output logic                     rd_valid,
    output logic                     addr_err,
    output logic [N_RW*DATA_W-1:0]   cfg_active,
    input  logic                     commit_req,
    output logic                     commit_ack,
    input  logic [N_RO*DATA_W-1:0]   status_in,
    input  logic [N_EVT-1:0]         evt_in,
    output logic                     irq,
    output logic [CMD_W-1:0]         cmd_pulse,
    output logic                     cmd_valid
);
    logic [DATA_W-1:0] shadow [N_RW];
    logic [DATA_W-1:0] active [N_RW];
    logic [ADDR_W-1:0] off;
    logic [DATA_W-1:0] rd_mux;
    logic [N_EVT-1:0] evt_sticky, evt_mask;
    logic dirty, wr_rw, wr_cmd;
    region_e region;
    int o, idx;
    // one decode feeds both the read mux and the write enables
    always_comb begin
        off = addr - BASE;
        o = int'(off);
        region = NONE;
        idx = 0;
        if (o >= 1 && o <= N_RW) begin
            region = RW;
            idx = o - 1;
        end else if (o >= OFS_RO && o < OFS_RO + N_RO) begin
            region = RO;
            idx = o - OFS_RO;
        end else begin
            region = o == OFS_EVT ? EVT : o == OFS_MASK ? MASK : o == OFS_DIRTY ? DIRTY :
                     o == OFS_CMD ? CMD : NONE;
        end
    end
    assign wr_rw = wr_en && region == RW;
    assign wr_cmd = wr_en && region == CMD;
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_RW; i++) if (region == RW && idx == i) rd_mux = shadow[i];
        for (int i = 0; i < N_RO; i++) if (region == RO && idx == i) rd_mux = status_in[i*DATA_W +: DATA_W];
        if (region == EVT) rd_mux = DATA_W'(evt_sticky);
        if (region == MASK) rd_mux = DATA_W'(evt_mask);
        if (region == DIRTY) rd_mux = DATA_W'(dirty);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_RW; i++) begin
                shadow[i] <= RW_RST[i*DATA_W +: DATA_W];
                active[i] <= RW_RST[i*DATA_W +: DATA_W];
            end
            dirty <= 1'b0;
            commit_ack <= 1'b0;
            read_data <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
            cmd_pulse <= '0;
            cmd_valid <= 1'b0;
        end else begin
            // commit copies the pre-write shadow; a same-cycle write lands in shadow and stays dirty
            for (int i = 0; i < N_RW; i++) begin
                if (commit_req) active[i] <= shadow[i];
                if (wr_rw && idx == i) shadow[i] <= write_data;
            end
            dirty <= wr_rw || (dirty && !commit_req);
            commit_ack <= commit_req;
            read_data <= rd_en ? rd_mux : '0;
            rd_valid <= rd_en;
            addr_err <= (rd_en || wr_en) && region == NONE;
            cmd_valid <= wr_cmd;
            cmd_pulse <= wr_cmd ? write_data[CMD_W-1:0] : '0;
        end
    end
    for (genvar g = 0; g < N_RW; g++) assign cfg_active[g*DATA_W +: DATA_W] = active[g];
    regfile_evt_sticky #(.N_EVT(N_EVT)) u_evt (
        .clk(clk),
        .rst(rst),
        .evt_in(evt_in),
        .clr_en(wr_en && region == EVT),
        .mask_we(wr_en && region == MASK),
        .wdata(write_data[N_EVT-1:0]),
        .evt_sticky(evt_sticky),
        .evt_mask(evt_mask),
        .irq(irq)
    );
endmodule

// File: tb/tb_regfile_bank_dbuf.sv
// tb_regfile_bank_dbuf: random + directed stimulus against a register-map level reference model
module tb_regfile_bank_dbuf;
    localparam logic [175:0] RST = {16'hAA0A, 16'hAA09, 16'hAA08, 16'hAA07, 16'hAA06, 16'hAA05,
                                    16'hAA04, 16'hAA03, 16'hAA02, 16'h1001, 16'hC0DE};
    logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0, commit_req = 1'b0;
    logic [13:0] addr = '0;
    logic [15:0] write_data = '0, evt_in = '0, read_data;
    logic [31:0] status_in = '0;
    logic [175:0] cfg_active;
    logic rd_valid, addr_err, commit_ack, irq, cmd_valid;
    logic [9:0] cmd_pulse;
    int n_chk = 0, n_fail = 0;
    logic chk_on = 1'b0;

    regfile_bank_dbuf #(.RW_RST(RST)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .write_data(write_data),
        .read_data(read_data), .rd_valid(rd_valid), .addr_err(addr_err), .cfg_active(cfg_active),
        .commit_req(commit_req), .commit_ack(commit_ack), .status_in(status_in), .evt_in(evt_in),
        .irq(irq), .cmd_pulse(cmd_pulse), .cmd_valid(cmd_valid)
    );

    always #5 clk = ~clk;

    // reference model: register map state plus the outputs expected after each edge
    logic [15:0] m_sh [11];
    logic [15:0] m_act [11];
    logic [15:0] m_stk, m_msk;
    logic m_dirty, e_rv, e_err, e_ack, e_irq, e_cv;
    logic [9:0] e_cp;
    logic [15:0] rdq [$];

    function automatic logic [15:0] lookup(int o);
        if (o >= 1 && o <= 11) return m_sh[o-1];
        if (o == 'h40 || o == 'h41) return status_in[(o-'h40)*16 +: 16];
        if (o == 'h60) return m_stk;
        if (o == 'h61) return m_msk;
        if (o == 'h62) return {15'h0, m_dirty};
        return 16'h0;
    endfunction

    function automatic logic mapped(int o);
        return (o >= 1 && o <= 11) || o == 'h40 || o == 'h41 || (o >= 'h60 && o <= 'h62) || o == 'h80;
    endfunction

    always @(posedge clk) begin
        int a;
        a = int'(addr);
        if (rst) begin
            for (int i = 0; i < 11; i++) begin
                m_sh[i] <= RST[i*16 +: 16];
                m_act[i] <= RST[i*16 +: 16];
            end
            {m_stk, m_msk} <= '0;
            {m_dirty, e_rv, e_err, e_ack, e_irq, e_cv} <= '0;
            e_cp <= '0;
            rdq.delete();
        end else begin
            if (rd_en) rdq.push_back(lookup(a));
            e_rv <= rd_en;
            e_err <= (rd_en || wr_en) && !mapped(a);
            e_ack <= commit_req;
            e_irq <= |(m_stk & m_msk);
            e_cv <= wr_en && a == 'h80;
            e_cp <= (wr_en && a == 'h80) ? write_data[9:0] : 10'h0;
            m_stk <= (m_stk & ~((wr_en && a == 'h60) ? write_data : 16'h0)) | evt_in;
            if (wr_en && a == 'h61) m_msk <= write_data;
            if (commit_req) m_act <= m_sh;
            if (wr_en && a >= 1 && a <= 11) m_sh[a-1] <= write_data;
            m_dirty <= (wr_en && a >= 1 && a <= 11) || (m_dirty && !commit_req);
        end
    end

    task automatic cmp(input string n, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // monitor: pops expected read data whenever the DUT presents rd_valid
    always @(negedge clk) begin
        logic [175:0] ec;
        logic [15:0] e;
        if (chk_on) begin
            for (int i = 0; i < 11; i++) ec[i*16 +: 16] = m_act[i];
            cmp("rd_valid", 256'(rd_valid), 256'(e_rv));
            if (rd_valid) begin
                if (rdq.size() == 0) cmp("rd_unexpected", 256'(rd_valid), 256'(0));
                else begin
                    e = rdq.pop_front();
                    cmp("read_data", 256'(read_data), 256'(e));
                end
            end else cmp("read_idle", 256'(read_data), 256'(0));
            cmp("addr_err", 256'(addr_err), 256'(e_err));
            cmp("commit_ack", 256'(commit_ack), 256'(e_ack));
            cmp("irq", 256'(irq), 256'(e_irq));
            cmp("cmd_valid", 256'(cmd_valid), 256'(e_cv));
            cmp("cmd_pulse", 256'(cmd_pulse), 256'(e_cp));
            cmp("cfg_active", 256'(cfg_active), 256'(ec));
        end
    end

    task automatic step(input logic r, we, re, input logic [13:0] a, input logic [15:0] wd,
                        input logic cr, input logic [15:0] ev);
        @(negedge clk);
        rst = r; wr_en = we; rd_en = re; addr = a; write_data = wd; commit_req = cr; evt_in = ev;
        status_in = $urandom;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 1'b0, 16'h0);
    endtask

    initial begin
        logic [13:0] pick [19];
        pick = '{14'h1, 14'h2, 14'h3, 14'h5, 14'hA, 14'hB, 14'h0, 14'hC, 14'h3F, 14'h40, 14'h41,
                 14'h42, 14'h60, 14'h61, 14'h62, 14'h63, 14'h7F, 14'h80, 14'h81};
        step(1'b1, 1'b0, 1'b0, 14'h0, 16'h0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 14'h0, 16'h0, 1'b0, 16'h0);
        chk_on = 1'b1;
        step(1'b0, 1'b0, 1'b1, 14'h01, 16'h0, 1'b0, 16'h0);
        idle();
        cmp("rst_read", 256'({rd_valid, read_data}), 256'({1'b1, 16'hC0DE}));
        cmp("rst_irq_cmd", 256'({irq, cmd_valid}), 256'(0));
        step(1'b0, 1'b1, 1'b0, 14'h02, 16'hBEEF, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 14'h62, 16'h0, 1'b0, 16'h0);
        cmp("dbuf_active_hold", 256'(cfg_active[31:16]), 256'(16'h1001));
        idle();
        cmp("dirty_set", 256'(read_data), 256'(1));
        step(1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 1'b1, 16'h0);
        step(1'b0, 1'b0, 1'b1, 14'h62, 16'h0, 1'b0, 16'h0);
        cmp("commit_active", 256'({commit_ack, cfg_active[31:16]}), 256'({1'b1, 16'hBEEF}));
        idle();
        cmp("dirty_clear_ack_pulse", 256'({commit_ack, read_data}), 256'(0));
        step(1'b0, 1'b1, 1'b0, 14'h03, 16'h1111, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 1'b1, 16'h0);
        step(1'b0, 1'b1, 1'b0, 14'h03, 16'h2222, 1'b1, 16'h0);
        step(1'b0, 1'b0, 1'b1, 14'h03, 16'h0, 1'b0, 16'h0);
        cmp("wc_active", 256'(cfg_active[47:32]), 256'(16'h1111));
        step(1'b0, 1'b0, 1'b1, 14'h62, 16'h0, 1'b0, 16'h0);
        cmp("wc_shadow", 256'(read_data), 256'(16'h2222));
        idle();
        cmp("wc_dirty", 256'(read_data), 256'(1));
        step(1'b0, 1'b1, 1'b0, 14'h61, 16'h0005, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 1'b0, 16'h0004);
        idle();
        idle();
        cmp("irq_set", 256'(irq), 256'(1));
        step(1'b0, 1'b1, 1'b0, 14'h60, 16'h0004, 1'b0, 16'h0004);
        step(1'b0, 1'b0, 1'b1, 14'h60, 16'h0, 1'b0, 16'h0);
        idle();
        cmp("set_wins", 256'(read_data), 256'(16'h0004));
        step(1'b0, 1'b1, 1'b0, 14'h60, 16'h0004, 1'b0, 16'h0);
        idle();
        idle();
        cmp("irq_clear", 256'(irq), 256'(0));
        step(1'b0, 1'b1, 1'b0, 14'h80, 16'h0201, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 14'h80, 16'h0, 1'b0, 16'h0);
        cmp("cmd_pulse_on", 256'({cmd_valid, cmd_pulse}), 256'({1'b1, 10'h201}));
        idle();
        cmp("cmd_pulse_off_read0", 256'({cmd_valid, rd_valid, read_data}), 256'({1'b0, 1'b1, 16'h0}));
        step(1'b0, 1'b0, 1'b1, 14'h3F, 16'h0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b0, 14'h7F, 16'hFFFF, 1'b0, 16'h0);
        cmp("unmapped_read", 256'({addr_err, read_data}), 256'({1'b1, 16'h0}));
        idle();
        cmp("unmapped_write", 256'(addr_err), 256'(1));
        step(1'b0, 1'b0, 1'b1, 14'h01, 16'h0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b1, 14'h01, 16'h0, 1'b0, 16'hFFFF);
        idle();
        cmp("rst_mid_read", 256'({rd_valid, addr_err, commit_ack, irq, cmd_valid, cmd_pulse, read_data}), 256'(0));
        cmp("rst_cfg", 256'(cfg_active), 256'(RST));
        for (int n = 0; n < 600; n++) begin
            int k;
            logic [13:0] a;
            k = $urandom_range(0, 19);
            a = (k == 19) ? 14'($urandom) : pick[k];
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4, a,
                 16'($urandom), $urandom_range(0, 9) < 2, 16'($urandom & $urandom & $urandom));
        end
        idle();
        idle();
        cmp("rdq_drained", 256'(rdq.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
